// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the fetch stage: halting instruction words,
// halt cause codes, the default reset PC and the fetch FSM state type.
package fetch_unit_pkg;

    localparam logic [31:0] ECALL_INST       = 32'h0000_0073;
    localparam logic [31:0] BAD_INST         = 32'hbadb_adff;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;

    typedef enum logic [1:0] {
        HaltNone       = 2'd0,
        HaltEcall      = 2'd1,
        HaltBadInst    = 2'd2,
        HaltMisaligned = 2'd3
    } halt_cause_e;

    typedef enum logic {
        StRun,
        StHalt
    } fetch_state_e;

    // Cause a word raises when decode pops it; HaltNone for ordinary instructions.
    function automatic halt_cause_e halt_code(input logic [31:0] word);
        if (word == ECALL_INST) begin
            return HaltEcall;
        end else if (word == BAD_INST) begin
            return HaltBadInst;
        end
        return HaltNone;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: DEPTH entries of {pc, instruction}, power-of-2 depth so the
// read/write pointers wrap naturally. Flush overrides push and pop.
module fetch_fifo #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [31:0]     push_inst,
    input  logic            pop,
    input  logic            flush,
    output logic [XLEN-1:0] head_pc,
    output logic [31:0]     head_inst,
    output logic [CW-1:0]   count
);

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // Storage and pointer/count update; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr_q]   <= push_pc;
                inst_mem[wr_ptr_q] <= push_inst;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign head_pc   = pc_mem[rd_ptr_q];
    assign head_inst = inst_mem[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, single-outstanding instruction-memory request,
// return queue toward decode, redirect handling and sticky halt FSM.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            halted,
    output logic [1:0]      halt_cause
);

    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

    fetch_state_e    state_q;
    halt_cause_e     cause_q;
    halt_cause_e     head_code;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic            inflight_q;
    logic [CW-1:0]   count;
    logic [CW:0]     space;
    logic            pop;
    logic            push;
    logic            flush;
    logic            halt_pop;
    logic            redirect_take;
    logic            misaligned;

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_pc   (inflight_pc_q),
        .push_inst (imem_rdata),
        .pop       (pop),
        .flush     (flush),
        .head_pc   (inst_pc),
        .head_inst (inst),
        .count     (count)
    );

    // Handshake, kill and issue decisions for the current cycle.
    always_comb begin
        inst_valid    = (count != '0);
        pop           = inst_valid & inst_ready;
        head_code     = halt_code(inst);
        halt_pop      = pop & (head_code != HaltNone);
        // A halting pop beats a same-cycle redirect; redirects are ignored once halted.
        redirect_take = redirect_valid & (state_q == StRun) & ~halt_pop;
        misaligned    = redirect_take & (redirect_pc[1:0] != 2'b00);
        flush         = halt_pop | redirect_take;
        push          = inflight_q & ~flush;
        // Slots free at the end of this cycle, counting the head leaving now.
        space         = (CW + 1)'(FQ_DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
        imem_req      = rst_n & (state_q == StRun) & ~redirect_valid & ~halt_pop
                        & (space > {{CW{1'b0}}, inflight_q});
        imem_addr     = pc_q;
        halted        = (state_q == StHalt);
        halt_cause    = cause_q;
    end

    // PC and in-flight request tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            if (redirect_take) begin
                pc_q <= redirect_pc;
            end else if (imem_req) begin
                pc_q <= pc_q + XLEN'(4);
            end
            inflight_q <= imem_req;
            if (imem_req) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    // Run/halt FSM; halt is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cause_q <= HaltNone;
        end else begin
            case (state_q)
                StRun: begin
                    if (halt_pop) begin
                        state_q <= StHalt;
                        cause_q <= head_code;
                    end else if (misaligned) begin
                        state_q <= StHalt;
                        cause_q <= HaltMisaligned;
                    end
                end
                default: state_q <= StHalt;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory model answers requests one cycle
// later, expected {pc, inst} pairs are queued when stimulus is set up and
// checked as decode pops them.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h0100_0000;
    localparam logic [31:0] NO_ADDR = 32'hffff_fff0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;
    logic [1:0]  halt_cause;

    logic [31:0] ecall_addr = NO_ADDR;
    logic [31:0] bad_addr   = NO_ADDR;
    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .halted         (halted),
        .halt_cause     (halt_cause)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == ecall_addr) return 32'h0000_0073;
        if (a == bad_addr) return 32'hbadb_adff;
        return a ^ 32'h5a5a_0000;
    endfunction

    // One-cycle synchronous instruction memory.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{pc: start + 32'(4 * i), word: mem_word(start + 32'(4 * i))});
        end
    endtask

    // Sample mid-cycle, score any pop, then advance to just after the next edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (imem_req) chk("req_aligned", 32'(imem_addr[1:0]), 32'h0);
        if (inst_valid && inst_ready) begin
            chk("pop_expected", 32'(sb.size() != 0), 32'h1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pop_pc", inst_pc, e.pc);
                chk("pop_inst", inst, e.word);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_cause", 32'(halt_cause), 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);

        // Fill and stream from the reset PC.
        #1 rst_n = 1'b1;
        push_seq(RST_PC, 16);
        #1;
        chk("t1_c0_req", 32'(imem_req), 32'h1);
        chk("t1_c0_addr", imem_addr, RST_PC);
        tick();
        chk("t1_c1_valid", 32'(inst_valid), 32'h0);
        tick();
        chk("t1_c2_valid", 32'(inst_valid), 32'h1);
        chk("t1_c2_pc", inst_pc, RST_PC);
        tick();
        chk("t1_c3_valid", 32'(inst_valid), 32'h1);
        chk("t1_c3_pc", inst_pc, RST_PC + 32'h4);
        tick();

        // Backpressure: queue fills, requests stop, order preserved on release.
        inst_ready = 1'b0;
        repeat (6) tick();
        chk("t2_req_stop", 32'(imem_req), 32'h0);
        chk("t2_valid", 32'(inst_valid), 32'h1);
        chk("t2_head", inst_pc, RST_PC + 32'h8);
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_nogap", 32'(inst_valid), 32'h1);
            tick();
        end

        // Redirect with a queued head and one request in flight.
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = RST_PC + 32'h40;
        #1;
        chk("t3_req_redirect", 32'(imem_req), 32'h0);
        sb.delete();
        push_seq(RST_PC + 32'h40, 8);
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        chk("t3_r1_valid", 32'(inst_valid), 32'h0);
        chk("t3_r1_addr", imem_addr, RST_PC + 32'h40);
        tick();
        chk("t3_r2_valid", 32'(inst_valid), 32'h0);
        tick();
        chk("t3_r3_valid", 32'(inst_valid), 32'h1);
        chk("t3_r3_pc", inst_pc, RST_PC + 32'h40);
        repeat (3) tick();

        // ECALL at 0x0100_0010 halts after being delivered.
        inst_ready     = 1'b0;
        ecall_addr     = RST_PC + 32'h10;
        redirect_valid = 1'b1;
        redirect_pc    = RST_PC + 32'h10;
        sb.delete();
        push_seq(RST_PC + 32'h10, 1);
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        n = 0;
        while (!halted && n < 10) begin
            tick();
            n++;
        end
        chk("t4_halted", 32'(halted), 32'h1);
        chk("t4_ecall_delivered", 32'(sb.size()), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = RST_PC + 32'h80;
        for (int i = 0; i < 20; i++) begin
            chk("t4_req", 32'(imem_req), 32'h0);
            chk("t4_valid", 32'(inst_valid), 32'h0);
            chk("t4_halted_sticky", 32'(halted), 32'h1);
            chk("t4_cause", 32'(halt_cause), 32'h1);
            tick();
        end
        redirect_valid = 1'b0;
        ecall_addr     = NO_ADDR;

        // Asynchronous reset out of halt, then mid-stream.
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_halted", 32'(halted), 32'h0);
        chk("t6_async_cause", 32'(halt_cause), 32'h0);
        chk("t6_async_req", 32'(imem_req), 32'h0);
        #2 rst_n = 1'b1;
        sb.delete();
        push_seq(RST_PC, 16);
        #1;
        chk("t6_restart_addr", imem_addr, RST_PC);
        repeat (5) tick();
        chk("t6_stream_valid", 32'(inst_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_mid_valid", 32'(inst_valid), 32'h0);
        chk("t6_mid_req", 32'(imem_req), 32'h0);
        chk("t6_mid_inst_pc", inst_pc, 32'h0);
        chk("t6_mid_inst", inst, 32'h0);
        @(posedge clk);
        #3;
        chk("t6_hold_valid", 32'(inst_valid), 32'h0);
        rst_n = 1'b1;
        sb.delete();
        push_seq(RST_PC, 16);
        #1;
        chk("t6_rel_req", 32'(imem_req), 32'h1);
        chk("t6_rel_addr", imem_addr, RST_PC);
        tick();
        tick();
        chk("t6_first_pc", inst_pc, RST_PC);
        repeat (3) tick();

        // Misaligned redirect halts without fetching the target.
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = RST_PC + 32'h42;
        #1;
        chk("t5_req_redirect", 32'(imem_req), 32'h0);
        sb.delete();
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        chk("t5_halted", 32'(halted), 32'h1);
        chk("t5_cause", 32'(halt_cause), 32'h3);
        chk("t5_valid", 32'(inst_valid), 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("t5_req", 32'(imem_req), 32'h0);
            tick();
        end

        // Out-of-range sentinel halts with cause 2.
        #2 rst_n = 1'b0;
        bad_addr = RST_PC + 32'h8;
        #2 rst_n = 1'b1;
        sb.delete();
        push_seq(RST_PC, 3);
        n = 0;
        while (!halted && n < 12) begin
            tick();
            n++;
        end
        chk("t6_bad_halted", 32'(halted), 32'h1);
        chk("t6_bad_cause", 32'(halt_cause), 32'h2);
        chk("t6_bad_delivered", 32'(sb.size()), 32'h0);
        chk("t6_bad_valid", 32'(inst_valid), 32'h0);
        repeat (3) tick();
        chk("t6_bad_req", 32'(imem_req), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
